trap_controller: RTL and testbench
==================================

# trap_controller

Machine-mode trap sequencer for the RV32 core. It sits after the exception pipeline's commit point and arbitrates between the committed synchronous exception, pending machine interrupts and `mret`. It sequences the single shared CSR write port through the trap-entry and trap-return updates, then issues the pipeline flush and PC redirect. While a sequence runs, it holds the pipeline stalled.

## Interface
Parameters:
- XLEN, 32, datapath/CSR width
- CAUSE_W, 5, width of exception cause code

Ports:
- clk  in  1  core clock
- rst_sync  in  1  synchronous, active-high reset
- commit_valid  in  1  a real instruction occupies the commit point this cycle
- commit_pc  in  XLEN  PC of the committing instruction
- exc_raise  in  1  committed synchronous exception
- exc_cause  in  CAUSE_W  exception code
- exc_tval  in  XLEN  trap value for the exception
- mret  in  1  committing instruction is `mret`
- irq_pending  in  3  {MEIP, MSIP, MTIP}
- irq_enable  in  3  {MEIE, MSIE, MTIE}
- mstatus  in  XLEN  current mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11)
- mtvec  in  XLEN  current mtvec (mode bits 1:0)
- mepc  in  XLEN  current mepc
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address: 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x300 mstatus
- csr_wdata  out  XLEN  CSR write data
- stall_n  out  1  pipeline advance enable; 0 holds the pipeline
- flush  out  1  one-cycle pipeline flush
- redirect_valid  out  1  PC redirect strobe; coincides with flush
- redirect_pc  out  XLEN  redirect target
- trap_busy  out  1  state != IDLE

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RET_STATUS, REDIRECT.
- Acceptance happens only in IDLE with commit_valid=1. Priority, highest first:
  1. exc_raise
  2. interrupt, when mstatus.MIE=1 and (irq_pending & irq_enable) != 0; within interrupts MEI (code 11) > MSI (3) > MTI (7)
  3. mret
- On acceptance, latch commit_pc, cause, interrupt flag, tval, mstatus and mepc.
  - Inputs are ignored for the rest of the sequence, except mtvec, which is sampled in REDIRECT.
  - For an interrupt, tval is 0.
  - mepc for an interrupt is commit_pc: that instruction has not executed and re-executes after return.
- Trap path: SAVE_EPC → SAVE_CAUSE → SAVE_TVAL → SAVE_STATUS → REDIRECT → IDLE.
  - SAVE_EPC writes mepc = {pc[XLEN-1:2], 2'b00}.
  - SAVE_CAUSE writes mcause = {intr, zero-extended code}.
  - SAVE_TVAL writes mtval.
  - SAVE_STATUS writes the latched mstatus with MPIE←MIE, MIE←0, MPP←2'b11.
- mret path: RET_STATUS → REDIRECT → IDLE.
  - RET_STATUS writes the latched mstatus with MIE←MPIE, MPIE←1, MPP←2'b11.
- REDIRECT target:
  - trap, mtvec mode 0: {mtvec[XLEN-1:2], 2'b00}
  - trap, mtvec mode 1 with an interrupt: base + 4·code
  - trap, mode 1 with an exception, or mode ≥2: treated as direct
  - mret: latched mepc with bits 1:0 cleared
- csr_we=1 exactly in the SAVE_* and RET_STATUS states. csr_waddr and csr_wdata are 0 otherwise.

## Timing
- All outputs are 0 during and after reset, except stall_n, which is 1.
- Reset in any state forces IDLE on the next edge. Any partially written CSR sequence is abandoned.
- stall_n is combinational:
  - 0 in the acceptance cycle and in every non-IDLE state
  - 1 in IDLE with no acceptance
- In REDIRECT, flush=1 and redirect_valid=1 for exactly one cycle; flush has priority over stall downstream.
- Trap accepted in cycle T:
  - CSR writes in T+1 (mepc), T+2 (mcause), T+3 (mtval), T+4 (mstatus)
  - flush/redirect in T+5
  - IDLE at T+6; a new acceptance is possible in T+6
- mret accepted in T: mstatus write in T+1, redirect in T+2.
- exc_raise and mret in the same cycle: the exception wins, and mret has no effect.
- An interrupt arriving mid-sequence is ignored until IDLE. With MIE now 0, it is taken only once software re-enables it.
- commit_valid=0 blocks all acceptance, including pending interrupts.

## Test plan
- Illegal-instruction exception (cause 2, tval 0xDEADBEEF, pc 0x100, mtvec 0x200, mstatus 0x8) → writes 0x341=0x100, 0x342=0x2, 0x343=0xDEADBEEF, 0x300=0x1880 in T+1..T+4; redirect_pc=0x200 with flush in T+5; stall_n=0 T..T+5.
- MTI pending, MTIE=1, MIE=1, mtvec 0x301 (vectored), pc 0x40 → mcause 0x80000007, mtval 0, mepc 0x40, redirect_pc=0x31C.
- MEIP+MSIP+MTIP all pending and enabled → mcause 0x8000000B. With MIE=0, no acceptance and stall_n stays 1.
- mret with mepc 0x104, mstatus 0x1880 → T+1 writes 0x300=0x1888, T+2 redirect_pc=0x104 with flush, IDLE at T+3.
- exc_raise and mret together, then a new exception asserted in T+3 → the first sequence is unaffected, and the second is accepted only at T+6.
- rst_sync asserted during SAVE_CAUSE → next cycle IDLE, csr_we=0, flush=0, stall_n=1, trap_busy=0.

Source files
------------

// File: rtl/trap_controller_if.sv
// Trap controller bus: commit-point inputs, CSR state inputs, and the
// CSR write / flush / redirect outputs of the machine-mode trap sequencer.
interface trap_controller_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
);
    logic               commit_valid;
    logic [XLEN-1:0]    commit_pc;
    logic               exc_raise;
    logic [CAUSE_W-1:0] exc_cause;
    logic [XLEN-1:0]    exc_tval;
    logic               mret;
    logic [2:0]         irq_pending;
    logic [2:0]         irq_enable;
    logic [XLEN-1:0]    mstatus;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;

    logic               csr_we;
    logic [11:0]        csr_waddr;
    logic [XLEN-1:0]    csr_wdata;
    logic               stall_n;
    logic               flush;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               trap_busy;

    // Pipeline / CSR file side
    modport master (
        output commit_valid, commit_pc, exc_raise, exc_cause, exc_tval, mret,
               irq_pending, irq_enable, mstatus, mtvec, mepc,
        input  csr_we, csr_waddr, csr_wdata, stall_n, flush,
               redirect_valid, redirect_pc, trap_busy
    );

    // Trap controller side
    modport slave (
        input  commit_valid, commit_pc, exc_raise, exc_cause, exc_tval, mret,
               irq_pending, irq_enable, mstatus, mtvec, mepc,
        output csr_we, csr_waddr, csr_wdata, stall_n, flush,
               redirect_valid, redirect_pc, trap_busy
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exception / interrupt / mret at the
// commit point, drives the shared CSR write port through the trap-entry or
// trap-return updates, then flushes and redirects the pipeline.
module trap_controller #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
) (
    input logic         clk,
    input logic         rst_sync,
    trap_controller_if.slave tc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_TVAL,
        SAVE_STATUS,
        RET_STATUS,
        REDIRECT
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [XLEN-1:0]    mstatus_q, mstatus_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               intr_q, intr_d;
    logic               ret_q, ret_d;

    logic               csr_we_q, csr_we_d;
    logic [11:0]        csr_waddr_q, csr_waddr_d;
    logic [XLEN-1:0]    csr_wdata_q, csr_wdata_d;
    logic               flush_q, flush_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic               trap_busy_q, trap_busy_d;

    logic [2:0]         irq_act;
    logic               idle_cv;
    logic               irq_ok;
    logic               take_exc, take_irq, take_ret, accept;
    logic [CAUSE_W-1:0] irq_code;
    logic [XLEN-1:0]    vec_base;
    logic [XLEN-1:0]    vec_off;
    logic [XLEN-1:0]    redirect_pc;
    logic [XLEN-1:0]    mcause_d;

    function automatic logic [XLEN-1:0] entry_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] return_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Acceptance arbitration: exception > enabled interrupt (MEI > MSI > MTI) > mret
    always_comb begin
        irq_act  = tc.irq_pending & tc.irq_enable;
        idle_cv  = !rst_sync && tc.commit_valid && (state_q == IDLE);
        irq_ok   = tc.mstatus[3] && (irq_act != 3'b000);
        take_exc = idle_cv && tc.exc_raise;
        take_irq = idle_cv && !tc.exc_raise && irq_ok;
        take_ret = idle_cv && !tc.exc_raise && !irq_ok && tc.mret;
        accept   = take_exc || take_irq || take_ret;
        if (irq_act[2]) begin
            irq_code = CAUSE_W'(11);
        end else if (irq_act[1]) begin
            irq_code = CAUSE_W'(3);
        end else begin
            irq_code = CAUSE_W'(7);
        end
    end

    // Next state, latched trap context, and registered outputs for the next state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tval_d      = tval_q;
        mstatus_d   = mstatus_q;
        mepc_d      = mepc_q;
        cause_d     = cause_q;
        intr_d      = intr_q;
        ret_d       = ret_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pc_d      = {tc.commit_pc[XLEN-1:2], 2'b00};
                    mstatus_d = tc.mstatus;
                    mepc_d    = {tc.mepc[XLEN-1:2], 2'b00};
                end
                if (take_exc) begin
                    state_d = SAVE_EPC;
                    cause_d = tc.exc_cause;
                    tval_d  = tc.exc_tval;
                    intr_d  = 1'b0;
                    ret_d   = 1'b0;
                end else if (take_irq) begin
                    state_d = SAVE_EPC;
                    cause_d = irq_code;
                    tval_d  = '0;
                    intr_d  = 1'b1;
                    ret_d   = 1'b0;
                end else if (take_ret) begin
                    state_d = RET_STATUS;
                    cause_d = '0;
                    tval_d  = '0;
                    intr_d  = 1'b0;
                    ret_d   = 1'b1;
                end
            end
            SAVE_EPC:    state_d = SAVE_CAUSE;
            SAVE_CAUSE:  state_d = SAVE_TVAL;
            SAVE_TVAL:   state_d = SAVE_STATUS;
            SAVE_STATUS: state_d = REDIRECT;
            RET_STATUS:  state_d = REDIRECT;
            REDIRECT:    state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        mcause_d                = '0;
        mcause_d[XLEN-1]        = intr_d;
        mcause_d[CAUSE_W-1:0]   = cause_d;

        csr_we_d         = 1'b0;
        csr_waddr_d      = '0;
        csr_wdata_d      = '0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        case (state_d)
            SAVE_EPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MEPC;
                csr_wdata_d = pc_d;
            end
            SAVE_CAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = mcause_d;
            end
            SAVE_TVAL: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MTVAL;
                csr_wdata_d = tval_d;
            end
            SAVE_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = entry_status(mstatus_d);
            end
            RET_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = return_status(mstatus_d);
            end
            REDIRECT: begin
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
            end
            default: ;
        endcase

        trap_busy_d = (state_d != IDLE);
    end

    // State, trap context and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q          <= IDLE;
            pc_q             <= '0;
            tval_q           <= '0;
            mstatus_q        <= '0;
            mepc_q           <= '0;
            cause_q          <= '0;
            intr_q           <= 1'b0;
            ret_q            <= 1'b0;
            csr_we_q         <= 1'b0;
            csr_waddr_q      <= '0;
            csr_wdata_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            trap_busy_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            tval_q           <= tval_d;
            mstatus_q        <= mstatus_d;
            mepc_q           <= mepc_d;
            cause_q          <= cause_d;
            intr_q           <= intr_d;
            ret_q            <= ret_d;
            csr_we_q         <= csr_we_d;
            csr_waddr_q      <= csr_waddr_d;
            csr_wdata_q      <= csr_wdata_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            trap_busy_q      <= trap_busy_d;
        end
    end

    // Redirect target; combinational because mtvec is sampled live in REDIRECT
    always_comb begin
        vec_base    = {tc.mtvec[XLEN-1:2], 2'b00};
        vec_off     = {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00};
        redirect_pc = '0;
        if (state_q == REDIRECT) begin
            if (ret_q) begin
                redirect_pc = mepc_q;
            end else if ((tc.mtvec[1:0] == 2'b01) && intr_q) begin
                redirect_pc = vec_base + vec_off;
            end else begin
                redirect_pc = vec_base;
            end
        end
    end

    assign tc.csr_we         = csr_we_q;
    assign tc.csr_waddr      = csr_waddr_q;
    assign tc.csr_wdata      = csr_wdata_q;
    assign tc.flush          = flush_q;
    assign tc.redirect_valid = redirect_valid_q;
    assign tc.redirect_pc    = redirect_pc;
    assign tc.trap_busy      = trap_busy_q;
    assign tc.stall_n        = rst_sync || ((state_q == IDLE) && !accept);

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: directed stimulus pushes expected
// CSR-write / redirect events; a negedge monitor pops and compares them and
// tracks the expected stall_n / trap_busy window.
module tb_trap_controller;

    logic clk = 1'b0;
    logic rst_sync = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   acc_cyc = 0;
    int   busy_until = -1;

    typedef struct {
        int          cyc;
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    trap_controller_if #(.XLEN(32), .CAUSE_W(5)) tc ();

    trap_controller #(.XLEN(32), .CAUSE_W(5)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic push_csr(input int c, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.cyc = c; e.is_redir = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_redir(input int c, input logic [31:0] pc);
        ev_t e;
        e.cyc = c; e.is_redir = 1'b1; e.addr = 12'h000; e.data = pc;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input int t, input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] st, input logic [31:0] tgt);
        push_csr(t + 1, 12'h341, epc);
        push_csr(t + 2, 12'h342, cause);
        push_csr(t + 3, 12'h343, tval);
        push_csr(t + 4, 12'h300, st);
        push_redir(t + 5, tgt);
    endtask

    task automatic drive(input logic cv, input logic exc, input logic ret, input logic [4:0] cause,
                         input logic [31:0] pc, input logic [31:0] tval, input logic [2:0] pend,
                         input logic [2:0] en, input logic [31:0] st, input logic [31:0] vec,
                         input logic [31:0] epc);
        tc.commit_valid = cv;
        tc.exc_raise    = exc;
        tc.mret         = ret;
        tc.exc_cause    = cause;
        tc.commit_pc    = pc;
        tc.exc_tval     = tval;
        tc.irq_pending  = pend;
        tc.irq_enable   = en;
        tc.mstatus      = st;
        tc.mtvec        = vec;
        tc.mepc         = epc;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every DUT output event; otherwise outputs must be idle
    always @(negedge clk) begin
        ev_t e;
        if (tc.csr_we === 1'b1 || tc.redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event at cycle %0d: we=%b rv=%b addr=%h data=%h",
                         cyc, tc.csr_we, tc.redirect_valid, tc.csr_waddr, tc.csr_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                if (e.is_redir) begin
                    chk("redirect_valid", {31'b0, tc.redirect_valid}, 32'd1);
                    chk("flush", {31'b0, tc.flush}, 32'd1);
                    chk("redirect_pc", tc.redirect_pc, e.data);
                    chk("csr_we_in_redirect", {31'b0, tc.csr_we}, 32'd0);
                end else begin
                    chk("csr_we", {31'b0, tc.csr_we}, 32'd1);
                    chk("csr_waddr", {20'b0, tc.csr_waddr}, {20'b0, e.addr});
                    chk("csr_wdata", tc.csr_wdata, e.data);
                    chk("flush_in_write", {31'b0, tc.flush}, 32'd0);
                end
            end
        end else if (!rst_sync) begin
            chk("idle_waddr", {20'b0, tc.csr_waddr}, 32'd0);
            chk("idle_wdata", tc.csr_wdata, 32'd0);
            chk("idle_flush", {31'b0, tc.flush}, 32'd0);
            chk("idle_redirect_pc", tc.redirect_pc, 32'd0);
        end
        if (!rst_sync) begin
            chk("stall_n", {31'b0, tc.stall_n},
                {31'b0, !(cyc >= acc_cyc && cyc <= busy_until)});
            chk("trap_busy", {31'b0, tc.trap_busy},
                {31'b0, (cyc > acc_cyc && cyc <= busy_until)});
        end
    end

    initial begin
        int t;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        rst_sync = 1'b1;
        step(3);
        rst_sync = 1'b0;
        step(1);

        // Reset state
        chk("rst_csr_we", {31'b0, tc.csr_we}, 32'd0);
        chk("rst_csr_waddr", {20'b0, tc.csr_waddr}, 32'd0);
        chk("rst_csr_wdata", tc.csr_wdata, 32'd0);
        chk("rst_flush", {31'b0, tc.flush}, 32'd0);
        chk("rst_redirect_valid", {31'b0, tc.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", tc.redirect_pc, 32'd0);
        chk("rst_trap_busy", {31'b0, tc.trap_busy}, 32'd0);
        chk("rst_stall_n", {31'b0, tc.stall_n}, 32'd1);
        step(2);

        // Illegal instruction; inputs change after acceptance and must be ignored
        drive(1, 1, 0, 5'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h8, 32'h200, 0);
        t = cyc; acc_cyc = t; busy_until = t + 5;
        push_trap(t, 32'h100, 32'h2, 32'hDEADBEEF, 32'h1880, 32'h200);
        step(1);
        drive(0, 0, 0, 5'd9, 32'h500, 32'h12345678, 0, 0, 32'h0, 32'h200, 32'h44);
        step(8);

        // Timer interrupt, vectored mtvec
        drive(1, 0, 0, 0, 32'h40, 32'h55, 3'b001, 3'b001, 32'h8, 32'h301, 0);
        t = cyc; acc_cyc = t; busy_until = t + 5;
        push_trap(t, 32'h40, 32'h80000007, 32'h0, 32'h1880, 32'h31C);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h301, 0);
        step(8);

        // All interrupts pending: MEI wins; direct mtvec
        drive(1, 0, 0, 0, 32'h80, 32'h55, 3'b111, 3'b111, 32'h8, 32'h200, 0);
        t = cyc; acc_cyc = t; busy_until = t + 5;
        push_trap(t, 32'h80, 32'h8000000B, 32'h0, 32'h1880, 32'h200);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        step(8);

        // MIE=0 masks pending interrupts; no acceptance, stall_n stays 1
        drive(1, 0, 0, 0, 32'h90, 0, 3'b111, 3'b111, 32'h0, 32'h200, 0);
        step(4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        step(2);

        // Exception with vectored mtvec is direct; unaligned pc cleared; MIE=0 gives MPIE=0
        drive(1, 1, 0, 5'd5, 32'h7, 32'h1234, 0, 0, 32'h0, 32'h301, 0);
        t = cyc; acc_cyc = t; busy_until = t + 5;
        push_trap(t, 32'h4, 32'h5, 32'h1234, 32'h1800, 32'h300);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h301, 0);
        step(8);

        // mret
        drive(1, 0, 1, 0, 32'h300, 0, 0, 0, 32'h1880, 32'h200, 32'h104);
        t = cyc; acc_cyc = t; busy_until = t + 2;
        push_csr(t + 1, 12'h300, 32'h1888);
        push_redir(t + 2, 32'h104);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        step(5);

        // mret with MPIE=0 and unaligned mepc
        drive(1, 0, 1, 0, 32'h300, 0, 0, 0, 32'h0, 32'h200, 32'h10B);
        t = cyc; acc_cyc = t; busy_until = t + 2;
        push_csr(t + 1, 12'h300, 32'h1880);
        push_redir(t + 2, 32'h108);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        step(5);

        // exc_raise + mret together, then a new exception held from T+3
        drive(1, 1, 1, 5'd3, 32'h200, 32'h44, 0, 0, 32'h8, 32'h400, 32'h999);
        t = cyc; acc_cyc = t; busy_until = t + 5;
        push_trap(t, 32'h200, 32'h3, 32'h44, 32'h1880, 32'h400);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h400, 0);
        step(2);
        drive(1, 1, 0, 5'd2, 32'h300, 32'h77, 0, 0, 32'h8, 32'h400, 0);
        step(3);
        acc_cyc = t + 6; busy_until = t + 11;
        push_trap(t + 6, 32'h300, 32'h2, 32'h77, 32'h1880, 32'h400);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h400, 0);
        step(8);

        // Reset during SAVE_CAUSE abandons the sequence
        drive(1, 1, 0, 5'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h8, 32'h200, 0);
        t = cyc; acc_cyc = t; busy_until = t + 2;
        push_csr(t + 1, 12'h341, 32'h100);
        push_csr(t + 2, 12'h342, 32'h2);
        step(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h200, 0);
        step(1);
        rst_sync = 1'b1;
        step(1);
        rst_sync = 1'b0;
        chk("post_rst_stall_n", {31'b0, tc.stall_n}, 32'd1);
        chk("post_rst_trap_busy", {31'b0, tc.trap_busy}, 32'd0);
        chk("post_rst_csr_we", {31'b0, tc.csr_we}, 32'd0);
        chk("post_rst_flush", {31'b0, tc.flush}, 32'd0);
        step(6);

        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
